// File: rtl/fnd_scan_controller.sv
// Four-digit FND scan sequencer: steps the digit select at a fixed slot rate,
// inserts a dark guard at each digit switch and swaps display words only between frames.
module fnd_scan_controller #(
  parameter int TICK_DIV  = 100000,
  parameter int GUARD_CYC = 1000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_dispOn,
  input  logic        i_load,
  input  logic [15:0] i_value,
  input  logic        i_blankLeadZero,
  output logic [1:0]  o_digitSelect,
  output logic [3:0]  o_value,
  output logic        o_en,
  output logic        o_pending,
  output logic        o_frameDone
);

  localparam int             CW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0]  TICK_LAST  = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0]  GUARD_LAST = CW'((GUARD_CYC > 0) ? GUARD_CYC - 1 : 0);
  localparam bit             HAS_GUARD  = (GUARD_CYC > 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GUARD = 2'd1,
    ON    = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0]    digit, digit_n;
  logic [15:0]   disp_reg, disp_n;
  logic [15:0]   shadow_reg;
  logic          pending, pending_n;
  logic          frame_bnd;
  logic          copy_shadow;

  function automatic logic [3:0] nibble_of(input logic [15:0] word, input logic [1:0] d);
    case (d)
      2'd0:    nibble_of = word[3:0];
      2'd1:    nibble_of = word[7:4];
      2'd2:    nibble_of = word[11:8];
      default: nibble_of = word[15:12];
    endcase
  endfunction

  // A digit is a leading zero when it and every more-significant nibble are zero.
  function automatic logic is_blanked(input logic [15:0] word, input logic [1:0] d,
                                      input logic blz);
    case (d)
      2'd1:    is_blanked = blz && (word[15:4] == 12'h000);
      2'd2:    is_blanked = blz && (word[15:8] == 8'h00);
      2'd3:    is_blanked = blz && (word[15:12] == 4'h0);
      default: is_blanked = 1'b0;
    endcase
  endfunction

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    digit_n   = digit;
    frame_bnd = (state == ON) && (cnt == TICK_LAST) && (digit == 2'd3);
    case (state)
      IDLE: begin
        cnt_n   = '0;
        digit_n = 2'd0;
        if (i_dispOn) state_n = HAS_GUARD ? GUARD : ON;
      end
      GUARD: begin
        if (!i_dispOn) begin
          state_n = IDLE;
          cnt_n   = '0;
          digit_n = 2'd0;
        end else begin
          cnt_n = cnt + 1'b1;
          if (cnt == GUARD_LAST) state_n = ON;
        end
      end
      ON: begin
        if (!i_dispOn) begin
          state_n = IDLE;
          cnt_n   = '0;
          digit_n = 2'd0;
        end else if (cnt == TICK_LAST) begin
          cnt_n   = '0;
          digit_n = digit + 2'd1;
          state_n = HAS_GUARD ? GUARD : ON;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        digit_n = 2'd0;
      end
    endcase

    // Shadow moves to the display only between frames, or at once while idle.
    copy_shadow = pending && (frame_bnd || (state == IDLE));
    disp_n      = copy_shadow ? shadow_reg : disp_reg;
    if (i_load)           pending_n = 1'b1;
    else if (copy_shadow) pending_n = 1'b0;
    else                  pending_n = pending;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      digit         <= 2'd0;
      disp_reg      <= 16'h0000;
      shadow_reg    <= 16'h0000;
      pending       <= 1'b0;
      o_digitSelect <= 2'd0;
      o_value       <= 4'h0;
      o_en          <= 1'b0;
      o_pending     <= 1'b0;
      o_frameDone   <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      digit    <= digit_n;
      disp_reg <= disp_n;
      pending  <= pending_n;
      if (i_load) shadow_reg <= i_value;
      // Outputs are registered from next-state values so they line up with the state register.
      o_digitSelect <= digit_n;
      o_value       <= nibble_of(disp_n, digit_n);
      o_en          <= (state_n == ON) && !is_blanked(disp_n, digit_n, i_blankLeadZero);
      o_pending     <= pending_n;
      o_frameDone   <= (state_n == ON) && (cnt_n == TICK_LAST) && (digit_n == 2'd3);
    end
  end

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Directed bench for fnd_scan_controller with TICK_DIV=8, GUARD_CYC=2.
module tb_fnd_scan_controller;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_dispOn;
  logic        i_load;
  logic [15:0] i_value;
  logic        i_blankLeadZero;
  logic [1:0]  o_digitSelect;
  logic [3:0]  o_value;
  logic        o_en;
  logic        o_pending;
  logic        o_frameDone;

  int n_checks = 0;
  int n_errors = 0;

  fnd_scan_controller #(.TICK_DIV(8), .GUARD_CYC(2)) dut (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .i_dispOn(i_dispOn),
    .i_load(i_load),
    .i_value(i_value),
    .i_blankLeadZero(i_blankLeadZero),
    .o_digitSelect(o_digitSelect),
    .o_value(o_value),
    .o_en(o_en),
    .o_pending(o_pending),
    .o_frameDone(o_frameDone)
  );

  always #5 i_clk = ~i_clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_sel"}, 16'(o_digitSelect), 16'h0);
    check_eq({tag, "_val"}, 16'(o_value), 16'h0);
    check_eq({tag, "_en"}, 16'(o_en), 16'h0);
    check_eq({tag, "_pend"}, 16'(o_pending), 16'h0);
    check_eq({tag, "_fd"}, 16'(o_frameDone), 16'h0);
  endtask

  // k counts cycles since the edge that left IDLE; slot = k/8, position = k%8.
  task automatic tick_check(input int k, input logic [15:0] word, input logic pend);
    int          d;
    int          c;
    logic [15:0] upper;
    logic        blank;
    tick;
    d     = (k / 8) % 4;
    c     = k % 8;
    upper = word >> (4 * d);
    blank = (d != 0) && i_blankLeadZero && (upper == 16'h0);
    check_eq($sformatf("sel@%0d", k), 16'(o_digitSelect), 16'(d));
    check_eq($sformatf("val@%0d", k), 16'(o_value), upper & 16'hF);
    check_eq($sformatf("en@%0d", k), 16'(o_en), 16'((c >= 2) && !blank));
    check_eq($sformatf("fd@%0d", k), 16'(o_frameDone), 16'((c == 7) && (d == 3)));
    check_eq($sformatf("pend@%0d", k), 16'(o_pending), 16'(pend));
  endtask

  // Drop to IDLE, load a word, and confirm it reaches the display without a frame wait.
  task automatic idle_load(input logic [15:0] word);
    i_dispOn = 1'b0;
    tick;
    i_load  = 1'b1;
    i_value = word;
    tick;
    i_load = 1'b0;
    check_eq("idle_pend_set", 16'(o_pending), 16'h1);
    check_eq("idle_en", 16'(o_en), 16'h0);
    tick;
    check_eq("idle_pend_clr", 16'(o_pending), 16'h0);
    check_eq("idle_val", 16'(o_value), 16'(word[3:0]));
    check_eq("idle_sel", 16'(o_digitSelect), 16'h0);
  endtask

  initial begin
    i_rst_n         = 1'b0;
    i_dispOn        = 1'b0;
    i_load          = 1'b0;
    i_value         = 16'h0000;
    i_blankLeadZero = 1'b0;
    #1;
    check_all_zero("rst_hold");
    repeat (2) tick;
    i_rst_n = 1'b1;
    repeat (3) tick;
    check_all_zero("post_rst_idle");

    // Basic scan of 0x1234 over one frame.
    idle_load(16'h1234);
    i_dispOn = 1'b1;
    for (int j = 0; j < 32; j++) tick_check(j, 16'h1234, 1'b0);

    // Load during digit 1: current frame keeps old word, next frame shows new.
    for (int j = 32; j < 96; j++) begin
      tick_check(j, (j < 64) ? 16'h1234 : 16'hABCD, (j >= 41) && (j < 64));
      i_load  = (j == 40);
      i_value = 16'hABCD;
    end

    // Two loads in one frame (last wins), then a load on the boundary cycle.
    for (int j = 96; j < 192; j++) begin
      tick_check(j, (j < 128) ? 16'hABCD : ((j < 160) ? 16'h2222 : 16'h3333),
                 (j >= 98) && (j < 160));
      i_load  = (j == 97) || (j == 104) || (j == 127);
      i_value = (j == 97) ? 16'h1111 : ((j == 104) ? 16'h2222 : 16'h3333);
    end

    // Drop enable mid-ON of digit 2, then restart from digit 0 with a full guard.
    for (int j = 192; j < 213; j++) tick_check(j, 16'h3333, 1'b0);
    check_eq("mid_on_en", 16'(o_en), 16'h1);
    check_eq("mid_on_sel", 16'(o_digitSelect), 16'h2);
    i_dispOn = 1'b0;
    tick;
    check_eq("drop_en", 16'(o_en), 16'h0);
    check_eq("drop_sel", 16'(o_digitSelect), 16'h0);
    check_eq("drop_val", 16'(o_value), 16'h3);
    i_dispOn = 1'b1;
    for (int j = 0; j < 32; j++) tick_check(j, 16'h3333, 1'b0);

    // Leading-zero blanking.
    i_blankLeadZero = 1'b1;
    idle_load(16'h0050);
    i_dispOn = 1'b1;
    for (int j = 0; j < 32; j++) tick_check(j, 16'h0050, 1'b0);
    idle_load(16'h0000);
    i_dispOn = 1'b1;
    for (int j = 0; j < 32; j++) tick_check(j, 16'h0000, 1'b0);

    // Asynchronous reset mid-slot while digit 0 is lit.
    for (int j = 0; j < 5; j++) tick_check(j, 16'h0000, 1'b0);
    check_eq("pre_rst_en", 16'(o_en), 16'h1);
    #2;
    i_rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    i_dispOn = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    for (int j = 0; j < 4; j++) begin
      tick;
      check_all_zero("rel_off");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
